int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Memory-mapped interrupt controller that sits directly downstream of the timer/counter devices and other peripherals.
- Collects their irq lines, latches edge or level requests, and applies mask and fixed priority.
- Presents a single interrupt plus claim/EOI handshake to the CPU through the device bus, on the same bus interface style as the timers.
- One interrupt is in service at a time (no nesting).

Parameters:
NSRC, 6, number of interrupt sources (1..16)
ADDR_WD, 4, device word-address width (add_i is [ADDR_WD:1])

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
add_i  in  ADDR_WD  register word address [ADDR_WD:1]
we_i  in  1  write strobe
re_i  in  1  read strobe (required for claim side-effect)
dat_i  in  32  write data
dat_o  out  32  registered read data
irq_i  in  NSRC  source requests (irq outputs of TC etc.), synchronous to clk_i
int_o  out  1  interrupt request to CPU, registered
int_id_o  out  4  id of highest-priority active source, registered (0 when int_o=0)

Behaviour:
- Reset (rst_i=0, async): CTRL=0, MASK=0, MODE=0, PEND=0, INSVC=0, irq_q=0, dat_o=0, int_o=0, int_id_o=0.
- Register map (word addr):
  - 0 CTRL: bit0 global enable, RW; other bits read 0.
  - 1 MASK: RW, bit i=1 enables source i.
  - 2 MODE: RW, bit i=1 edge, 0 level.
  - 3 PEND: read; write-1-clear, edge sources only.
  - 4 CLAIM: read only, with side-effect.
  - 5 EOI: write only; reads 0.
  - Unmapped addresses: reads 0, writes ignored.
  - Bits >= NSRC read 0.
- irq_q <= irq_i every cycle.
- Edge source i: PEND[i] sets when irq_i[i]=1 && irq_q[i]=0. Clears by W1C write or by claim. Set beats clear in the same cycle.
- Level source i: PEND[i] <= irq_i[i] every cycle. W1C and claim have no effect on PEND.
- ACTIVE = PEND & MASK & ~INSVC.
- Priority is fixed: lowest index wins.
- int_o <= CTRL[0] && (ACTIVE != 0) && (INSVC == 0); int_id_o <= winning index, or 0.
- Latency: irq_i edge to int_o = 2 cycles (PEND then int_o).
- Claim: re_i=1, we_i=0, add=4.
  - Next edge: dat_o = {valid, 27'b0, id}, where valid=int_o of the current cycle and id=int_id_o.
  - If valid: INSVC[id] sets; if source id is edge, PEND[id] clears unless a new edge arrives in the same cycle.
  - If not valid: dat_o=0, no state change.
- EOI: we_i=1, add=5, dat_i[3:0]=id. Clears INSVC[id] if set; otherwise ignored. int_o may reassert the following cycle.
- Read path: dat_o updates only on cycles with re_i=1 && we_i=0, with 1-cycle latency; otherwise dat_o holds. re_i is ignored when we_i=1.
- A write takes effect at the clock edge; int_o reflects new MASK/CTRL one cycle later.
- Disabling CTRL[0] while a source is in service keeps INSVC; int_o drops next cycle.
- MODE change on a source: PEND[i] is cleared in the same cycle.
- Reset mid-claim or mid-service: all state clears; int_o=0 immediately (async).

Test Plan:
- Reset, CTRL=1, MASK=0x3F, MODE=0x01, pulse irq_i[0] one cycle -> int_o=1, int_id_o=0 two cycles later; PEND reads 0x01.
- Claim read -> dat_o=0x80000000, PEND[0]=0, int_o=0; EOI id 0 -> int_o stays 0.
- Level sources 2 and 4 held high, MODE=0 -> int_id_o=2. Claim -> dat_o=0x80000002, int_o=0 while in service. EOI 2 with irq_i[2] still high -> int_id_o=2 again. Drop irq_i[2], claim/EOI -> int_id_o=4.
- MASK=0x3E with irq_i[0] edge -> int_o stays 0, PEND[0]=1. Write MASK=0x3F -> int_o=1 one cycle after the write.
- Edge on source 1 in the same cycle as W1C of PEND bit1 -> PEND[1] stays 1. Claim with nothing active -> dat_o=0. EOI of a non-serviced id -> no change.
- Assert rst_i=0 while INSVC[3]=1 and int_o=1 -> int_o, dat_o and all registers 0 immediately. Release reset -> int_o remains 0 until re-enabled.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller. Captures edge/level requests,
// applies mask and fixed lowest-index priority, and hands one interrupt at a time to the CPU.
module int_ctrl #(
  parameter int NSRC    = 6,
  parameter int ADDR_WD = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_WD:1]   add_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  input  logic [NSRC-1:0]    irq_i,
  output logic               int_o,
  output logic [3:0]         int_id_o
);

  localparam logic [ADDR_WD:1] A_CTRL  = ADDR_WD'(0);
  localparam logic [ADDR_WD:1] A_MASK  = ADDR_WD'(1);
  localparam logic [ADDR_WD:1] A_MODE  = ADDR_WD'(2);
  localparam logic [ADDR_WD:1] A_PEND  = ADDR_WD'(3);
  localparam logic [ADDR_WD:1] A_CLAIM = ADDR_WD'(4);
  localparam logic [ADDR_WD:1] A_EOI   = ADDR_WD'(5);

  logic            r_ctrl;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_insvc;
  logic [NSRC-1:0] r_irq_q;
  logic [31:0]     r_dat;
  logic            r_int;
  logic [3:0]      r_int_id;

  logic            w_rd;
  logic            w_wr_ctrl;
  logic            w_wr_mask;
  logic            w_wr_mode;
  logic            w_wr_pend;
  logic            w_eoi;
  logic            w_claim_ok;
  logic [NSRC-1:0] w_mode_chg;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_insvc_nxt;
  logic [NSRC-1:0] w_active;
  logic [3:0]      w_win;
  logic            w_int_nxt;
  logic [3:0]      w_id_nxt;
  logic [31:0]     w_rd_data;
  logic            w_unused;

  assign w_rd       = re_i & ~we_i;
  assign w_wr_ctrl  = we_i & (add_i == A_CTRL);
  assign w_wr_mask  = we_i & (add_i == A_MASK);
  assign w_wr_mode  = we_i & (add_i == A_MODE);
  assign w_wr_pend  = we_i & (add_i == A_PEND);
  assign w_eoi      = we_i & (add_i == A_EOI);
  // A claim only grants when an interrupt is actually being presented this cycle
  assign w_claim_ok = w_rd & (add_i == A_CLAIM) & r_int;
  assign w_mode_chg = w_wr_mode ? (dat_i[NSRC-1:0] ^ r_mode) : {NSRC{1'b0}};
  assign w_active   = r_pend & r_mask & ~r_insvc;
  assign w_int_nxt  = r_ctrl & (|w_active) & ~(|r_insvc);
  assign w_id_nxt   = w_int_nxt ? w_win : 4'd0;
  assign w_unused   = ^dat_i[31:NSRC];

  assign dat_o    = r_dat;
  assign int_o    = r_int;
  assign int_id_o = r_int_id;

  // Per-source pending and in-service next state
  always_comb begin
    w_pend_nxt  = r_pend;
    w_insvc_nxt = r_insvc;
    for (int i = 0; i < NSRC; i++) begin
      if (w_mode_chg[i]) begin
        w_pend_nxt[i] = 1'b0;
      end else if (!r_mode[i]) begin
        w_pend_nxt[i] = irq_i[i];
      end else if (irq_i[i] & ~r_irq_q[i]) begin
        w_pend_nxt[i] = 1'b1;
      end else if ((w_wr_pend & dat_i[i]) | (w_claim_ok & (r_int_id == 4'(i)))) begin
        w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = r_pend[i];
      end

      if (w_claim_ok & (r_int_id == 4'(i))) begin
        w_insvc_nxt[i] = 1'b1;
      end else if (w_eoi & (dat_i[3:0] == 4'(i))) begin
        w_insvc_nxt[i] = 1'b0;
      end else begin
        w_insvc_nxt[i] = r_insvc[i];
      end
    end
  end

  // Fixed priority: scan downwards so the lowest active index is the last to land
  always_comb begin
    w_win = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_win = 4'(i);
      end else begin
        w_win = w_win;
      end
    end
  end

  // Register read multiplexer, including the claim response word
  always_comb begin
    w_rd_data = 32'd0;
    case (add_i)
      A_CTRL:  w_rd_data = {31'd0, r_ctrl};
      A_MASK:  w_rd_data = {{(32-NSRC){1'b0}}, r_mask};
      A_MODE:  w_rd_data = {{(32-NSRC){1'b0}}, r_mode};
      A_PEND:  w_rd_data = {{(32-NSRC){1'b0}}, r_pend};
      A_CLAIM: w_rd_data = r_int ? {1'b1, 27'd0, r_int_id} : 32'd0;
      default: w_rd_data = 32'd0;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl   <= 1'b0;
      r_mask   <= {NSRC{1'b0}};
      r_mode   <= {NSRC{1'b0}};
      r_pend   <= {NSRC{1'b0}};
      r_insvc  <= {NSRC{1'b0}};
      r_irq_q  <= {NSRC{1'b0}};
      r_dat    <= 32'd0;
      r_int    <= 1'b0;
      r_int_id <= 4'd0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= dat_i[0];
      else           r_ctrl <= r_ctrl;
      if (w_wr_mask) r_mask <= dat_i[NSRC-1:0];
      else           r_mask <= r_mask;
      if (w_wr_mode) r_mode <= dat_i[NSRC-1:0];
      else           r_mode <= r_mode;
      if (w_rd)      r_dat  <= w_rd_data;
      else           r_dat  <= r_dat;
      r_pend   <= w_pend_nxt;
      r_insvc  <= w_insvc_nxt;
      r_irq_q  <= irq_i;
      r_int    <= w_int_nxt;
      r_int_id <= w_id_nxt;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and randomized checks of int_ctrl against a cycle-level
// reference model built directly from the controller's register rules.
module tb_int_ctrl;
  localparam int NSRC = 6;
  localparam int AW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [AW:1]     add_i;
  logic            we_i;
  logic            re_i;
  logic [31:0]     dat_i;
  logic [31:0]     dat_o;
  logic [NSRC-1:0] irq_i;
  logic            int_o;
  logic [3:0]      int_id_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_ctrl;
  bit [NSRC-1:0] m_mask, m_mode, m_pend, m_insvc, m_irqq;
  bit            m_int;
  int            m_id;
  bit [31:0]     m_dat;

  int_ctrl #(.NSRC(NSRC), .ADDR_WD(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .add_i(add_i), .we_i(we_i), .re_i(re_i),
    .dat_i(dat_i), .dat_o(dat_o), .irq_i(irq_i), .int_o(int_o), .int_id_o(int_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 1'b0; m_mask = '0; m_mode = '0; m_pend = '0; m_insvc = '0;
    m_irqq = '0; m_int = 1'b0; m_id = 0; m_dat = 32'd0;
  endtask

  // one clock: predict from current inputs, clock the DUT, compare outputs
  task automatic tick();
    int            a;
    bit            claim;
    bit            n_ctrl, n_int;
    bit [NSRC-1:0] n_mask, n_mode, n_pend, n_insvc, act;
    int            n_id;
    bit [31:0]     n_dat;
    a = int'(add_i);
    claim = re_i && !we_i && (a == 4);
    n_ctrl = m_ctrl; n_mask = m_mask; n_mode = m_mode; n_pend = m_pend;
    n_insvc = m_insvc; n_dat = m_dat;
    if (re_i && !we_i) begin
      case (a)
        0: n_dat = {31'd0, m_ctrl};
        1: n_dat = 32'(m_mask);
        2: n_dat = 32'(m_mode);
        3: n_dat = 32'(m_pend);
        4: n_dat = m_int ? (32'h8000_0000 | 32'(m_id)) : 32'd0;
        default: n_dat = 32'd0;
      endcase
    end
    if (we_i) begin
      case (a)
        0: n_ctrl = dat_i[0];
        1: n_mask = dat_i[NSRC-1:0];
        2: n_mode = dat_i[NSRC-1:0];
        5: for (int i = 0; i < NSRC; i++) if (int'(dat_i[3:0]) == i) n_insvc[i] = 1'b0;
        default: ;
      endcase
    end
    if (claim && m_int) n_insvc[m_id] = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (we_i && a == 2 && dat_i[i] != m_mode[i])             n_pend[i] = 1'b0;
      else if (!m_mode[i])                                      n_pend[i] = irq_i[i];
      else if (irq_i[i] && !m_irqq[i])                          n_pend[i] = 1'b1;
      else if ((we_i && a == 3 && dat_i[i]) || (claim && m_int && m_id == i)) n_pend[i] = 1'b0;
    end
    act   = m_pend & m_mask & ~m_insvc;
    n_int = m_ctrl && (act != 0) && (m_insvc == 0);
    n_id  = 0;
    if (n_int) begin
      for (int i = 0; i < NSRC; i++) if (act[i]) begin n_id = i; break; end
    end
    @(posedge clk_i);
    #1;
    m_ctrl = n_ctrl; m_mask = n_mask; m_mode = n_mode; m_pend = n_pend;
    m_insvc = n_insvc; m_irqq = irq_i; m_int = n_int; m_id = n_id; m_dat = n_dat;
    chk("model_int_o", 32'(int_o), 32'(m_int));
    chk("model_int_id", 32'(int_id_o), 32'(m_id));
    chk("model_dat_o", dat_o, m_dat);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    add_i = AW'(a); dat_i = d; we_i = 1'b1;
    tick();
    we_i = 1'b0; dat_i = 32'd0; add_i = '0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    add_i = AW'(a); re_i = 1'b1;
    tick();
    re_i = 1'b0; add_i = '0;
    v = dat_o;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] d;
    int a, r;
    add_i = '0; we_i = 1'b0; re_i = 1'b0; dat_i = 32'd0; irq_i = '0;
    model_reset();
    #1 rst_i = 1'b0;
    #20;
    chk("rst_int_o", 32'(int_o), 32'd0);
    chk("rst_int_id", 32'(int_id_o), 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    #3 rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      chk("rst_reg", v, 32'd0);
    end

    // edge source 0
    wr(0, 32'd1); wr(1, 32'h3F); wr(2, 32'h01);
    irq_i = 6'b000001; tick(); irq_i = '0; tick();
    chk("edge_int", 32'(int_o), 32'd1);
    chk("edge_id", 32'(int_id_o), 32'd0);
    rd(3, v); chk("edge_pend", v, 32'h01);

    // claim and EOI of source 0
    rd(4, v); chk("claim0", v, 32'h8000_0000);
    tick(); chk("insvc_int_low", 32'(int_o), 32'd0);
    rd(3, v); chk("claim0_pend", v, 32'd0);
    wr(5, 32'd0); tick(); tick();
    chk("eoi0_int", 32'(int_o), 32'd0);

    // level sources 2 and 4
    wr(2, 32'd0);
    irq_i = 6'b010100; tick(); tick();
    chk("lvl_int", 32'(int_o), 32'd1);
    chk("lvl_id2", 32'(int_id_o), 32'd2);
    rd(4, v); chk("claim2", v, 32'h8000_0002);
    tick(); chk("lvl_svc_int", 32'(int_o), 32'd0);
    wr(5, 32'd2); tick();
    chk("lvl_reassert", 32'(int_o), 32'd1);
    chk("lvl_reassert_id", 32'(int_id_o), 32'd2);
    irq_i = 6'b010000; tick(); tick();
    chk("lvl_id4", 32'(int_id_o), 32'd4);
    rd(4, v); chk("claim4", v, 32'h8000_0004);
    tick(); wr(5, 32'd4); irq_i = '0; tick(); tick();
    chk("lvl_done", 32'(int_o), 32'd0);

    // masked edge, then unmask
    wr(2, 32'h01); wr(1, 32'h3E);
    irq_i = 6'b000001; tick(); irq_i = '0; tick(); tick();
    chk("masked_int", 32'(int_o), 32'd0);
    rd(3, v); chk("masked_pend", v, 32'h01);
    wr(1, 32'h3F);
    chk("unmask_lat", 32'(int_o), 32'd0);
    tick();
    chk("unmask_int", 32'(int_o), 32'd1);
    chk("unmask_id", 32'(int_id_o), 32'd0);
    rd(4, v); chk("claim0b", v, 32'h8000_0000);
    tick(); wr(5, 32'd0); tick(); tick();

    // edge beats W1C; empty claim; stray EOI
    wr(2, 32'h03);
    irq_i = 6'b000010; wr(3, 32'h02); irq_i = '0;
    rd(3, v); chk("set_beats_clr", v, 32'h02);
    wr(3, 32'h02); tick();
    rd(3, v); chk("w1c_pend", v, 32'd0);
    tick(); tick();
    rd(4, v); chk("claim_none", v, 32'd0);
    wr(5, 32'd3); tick();
    chk("stray_eoi_int", 32'(int_o), 32'd0);
    chk("stray_eoi_id", 32'(int_id_o), 32'd0);

    // async reset during service
    wr(2, 32'd0);
    irq_i = 6'b001000; tick(); tick();
    chk("svc3_id", 32'(int_id_o), 32'd3);
    rd(4, v); chk("claim3", v, 32'h8000_0003);
    chk("svc3_int_hi", 32'(int_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("async_int_o", 32'(int_o), 32'd0);
    chk("async_int_id", 32'(int_id_o), 32'd0);
    chk("async_dat_o", dat_o, 32'd0);
    model_reset();
    #2 rst_i = 1'b1;
    rd(3, v); chk("post_rst_pend", v, 32'd0);
    for (int i = 0; i < 3; i++) begin
      rd(i, v);
      chk("post_rst_reg", v, 32'd0);
    end
    tick(); tick();
    chk("post_rst_int", 32'(int_o), 32'd0);
    wr(0, 32'd1); wr(1, 32'h3F); tick(); tick();
    chk("reenable_id", 32'(int_id_o), 32'd3);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      irq_i = irq_i ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      r = $urandom_range(0, 9);
      if (r < 4) begin
        tick();
      end else if (r < 7) begin
        a = $urandom_range(0, 7);
        d = $urandom;
        if (a == 5) d = 32'($urandom_range(0, 7));
        re_i = 1'($urandom_range(0, 1));
        wr(a, d);
        re_i = 1'b0;
      end else begin
        a = ($urandom_range(0, 1) == 1) ? 4 : $urandom_range(0, 7);
        rd(a, v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
